mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, synchronous-read 4KB word memory between the instruction-fetch
//  port (I) and the load/store port (D) of the MIPS core.
//  Sits between the IF/MEM stages and the unified RAM: selects one requester per access,
//  drives the RAM control signals and returns read data with an ack.
//  The core stalls on a port until that port's ack. D has priority; I is starvation-protected.
// PARAMETERS
//  ADDR_W        10  word-address width; memory depth = 2**ADDR_W words (1024 = 4KB)
//  MAX_D_STREAK  4   max consecutive D grants while i_req is pending; then I wins once
// PORTS
//  clk       in   1       clock, all state on rising edge
//  rst       in   1       asynchronous, active-high reset
//  i_req     in   1       instruction read request; hold with i_addr stable until i_ack
//  i_addr    in   32      byte address; bits[1:0] ignored
//  i_rdata   out  32      instruction word, valid while i_ack=1
//  i_ack     out  1       one-cycle pulse: I access complete
//  i_err     out  1       with i_ack: address out of range, i_rdata=0
//  d_req     in   1       data request; hold with d_we/d_be/d_addr/d_wdata stable until d_ack
//  d_we      in   1       1=write, 0=read
//  d_be      in   4       byte enables for write (bit n -> byte lane n)
//  d_addr    in   32      byte address; bits[1:0] ignored
//  d_wdata   in   32      write data
//  d_rdata   out  32      read word, valid while d_ack=1; 0 on writes
//  d_ack     out  1       one-cycle pulse: D access complete
//  d_err     out  1       with d_ack: address out of range, no write performed
//  m_ce      out  1       RAM chip enable
//  m_we      out  4       RAM byte write enables
//  m_addr    out  ADDR_W  RAM word address
//  m_wdata   out  32      RAM write data
//  m_rdata   in   32      RAM read data, valid the cycle after m_ce (1-cycle latency)
// BEHAVIOUR
//  - Reset: state=IDLE; streak=0; all outputs 0.
//    Async assert mid-access aborts it: no ack issued, m_ce/m_we drop immediately.
//  - FSM states: IDLE, RESP_I, RESP_D. Each access takes 2 cycles; peak throughput is 1 per 2 cycles.
//  - IDLE, cycle N: arbitrate among requests present in that cycle.
//      only i_req -> grant I;  only d_req -> grant D
//      both -> D, unless streak==MAX_D_STREAK -> I
//    The granted port's signals drive m_* combinationally in cycle N:
//      m_addr = addr[ADDR_W+1:2];  m_ce=1;  m_we = (D write) ? d_be : 0;  m_wdata = d_wdata
//    Next state: RESP_I or RESP_D. No request -> stay IDLE, m_ce=0.
//  - Out of range (addr[31:ADDR_W+2] != 0): m_ce=0 and m_we=0 in cycle N.
//    State still advances; err=1 with the ack.
//  - RESP_x, cycle N+1: x_ack=1; x_rdata = (read && !err) ? m_rdata : 0. m_ce=0.
//    Next state IDLE. The non-granted port's ack/rdata stay 0.
//  - req still high in N+2 (IDLE) is a new request; the requester deasserts in N+2 if it is done.
//  - streak (3-bit sat.) is updated on each grant:
//      D grant with i_req=1 -> streak+1
//      I grant -> 0;  i_req=0 at grant -> 0
//  - Requester changing inputs before its ack is a protocol error; behaviour is undefined.
// TESTING
//  1. i_req, i_addr=0x8 held; RAM word2=0x8f990008 -> m_ce,m_addr=2 in N; i_ack, i_rdata=0x8f990008 in N+1.
//  2. d_req write d_addr=0x40, d_be=4'b0011, d_wdata=0xAABBCCDD -> m_we=0011, m_addr=0x10;
//     d_ack, d_rdata=0 in N+1; a following read returns the low half updated.
//  3. i_req and d_req held continuously -> grant order D,D,D,D,I,D,D,D,D,I; each ack 2 cycles apart.
//  4. d_req read d_addr=0x1000 (word 1024) -> m_ce=0 all cycles; d_ack=1, d_err=1, d_rdata=0.
//  5. rst pulse during RESP_D -> no d_ack; all outputs 0 immediately;
//     after release, a pending i_req is granted in the first IDLE cycle.
//  6. d_addr=0x43 read -> identical to 0x40 (byte offset ignored), d_err=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the instruction-fetch port, the load/store port
//                and the unified single-port RAM port served by
//                mem_port_arbiter.
//                  i_req/i_addr            -> instruction read request
//                  i_rdata/i_ack/i_err     <- instruction response
//                  d_req/d_we/d_be/d_addr/
//                  d_wdata                 -> load/store request
//                  d_rdata/d_ack/d_err     <- load/store response
//                  m_ce/m_we/m_addr/
//                  m_wdata                 <- RAM control (from arbiter)
//                  m_rdata                 -> RAM read data (1-cycle latency)
//                "slave" is the arbiter's view; "master" is the core+RAM
//                side that drives requests and read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    // Instruction port
    logic              i_req;
    logic [31:0]       i_addr;
    logic [31:0]       i_rdata;
    logic              i_ack;
    logic              i_err;
    // Data port
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic              d_err;
    // RAM port
    logic              m_ce;
    logic [3:0]        m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_ack, d_err,
        output m_ce, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_ack, d_err,
        input  m_ce, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port, synchronous-read word RAM between the
//                instruction-fetch port (I) and the load/store port (D).
//                Every access takes two cycles: the grant/RAM-drive cycle in
//                IDLE, then the response cycle (RESP_I / RESP_D) in which the
//                RAM read data is returned together with a one-cycle ack.
//                D has priority; after MAX_D_STREAK consecutive D grants made
//                while I was waiting, I wins once.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - asynchronous active-high reset
//                bus  - mem_port_arbiter_if.slave (I port, D port, RAM port)
//  Parameters  : ADDR_W       - RAM word-address width (depth 2**ADDR_W)
//                MAX_D_STREAK - D grants tolerated while I waits
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int MAX_D_STREAK = 4
) (
    input  wire                  clk,
    input  wire                  rst,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP_I = 2'd1,
        ST_RESP_D = 2'd2
    } state_t;

    localparam logic [2:0] c_MAX_STREAK = 3'(MAX_D_STREAK);
    localparam logic [2:0] c_STREAK_SAT = 3'd7;

    state_t      r_state;
    logic [2:0]  r_streak;     // consecutive D grants while I was waiting
    logic        r_err;        // granted access was out of range
    logic        r_d_read;     // granted D access was a read

    logic        w_idle;
    logic        w_i_oor;
    logic        w_d_oor;
    logic        w_i_starved;
    logic        w_grant_d;
    logic        w_grant_i;

    // Byte-offset bits never select anything in a word RAM.
    logic        w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.i_addr[1:0], bus.d_addr[1:0]};

    // ------------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE)
    // ------------------------------------------------------------------------
    assign w_idle      = (r_state == ST_IDLE);
    assign w_i_oor     = |(bus.i_addr >> (ADDR_W + 2));
    assign w_d_oor     = |(bus.d_addr >> (ADDR_W + 2));
    assign w_i_starved = bus.i_req && (r_streak == c_MAX_STREAK);
    assign w_grant_d   = w_idle && bus.d_req && !w_i_starved;
    assign w_grant_i   = w_idle && bus.i_req && !w_grant_d;

    // ------------------------------------------------------------------------
    // RAM drive: combinational from the granted port in the grant cycle.
    // Gated by rst so an asynchronous reset drops the RAM strobes at once,
    // even while a request is still held on the inputs.
    // ------------------------------------------------------------------------
    always_comb begin
        bus.m_ce    = 1'b0;
        bus.m_we    = 4'b0000;
        bus.m_addr  = '0;
        bus.m_wdata = 32'h0;
        if (!rst) begin
            if (w_grant_d) begin
                bus.m_addr  = bus.d_addr[ADDR_W+1:2];
                bus.m_wdata = bus.d_wdata;
                // Out-of-range accesses advance the FSM but never touch RAM.
                bus.m_ce    = !w_d_oor;
                bus.m_we    = (!w_d_oor && bus.d_we) ? bus.d_be : 4'b0000;
            end else if (w_grant_i) begin
                bus.m_addr  = bus.i_addr[ADDR_W+1:2];
                bus.m_ce    = !w_i_oor;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response: acks come straight from the state register; read data is the
    // RAM output of the response cycle, forced to zero for writes and errors.
    // ------------------------------------------------------------------------
    always_comb begin
        bus.i_ack   = (r_state == ST_RESP_I);
        bus.d_ack   = (r_state == ST_RESP_D);
        bus.i_err   = bus.i_ack && r_err;
        bus.d_err   = bus.d_ack && r_err;
        bus.i_rdata = (bus.i_ack && !r_err) ? bus.m_rdata : 32'h0;
        bus.d_rdata = (bus.d_ack && r_d_read && !r_err) ? bus.m_rdata : 32'h0;
    end

    // ------------------------------------------------------------------------
    // FSM and streak counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_streak <= 3'd0;
            r_err    <= 1'b0;
            r_d_read <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state  <= ST_RESP_D;
                        r_err    <= w_d_oor;
                        r_d_read <= !bus.d_we;
                        // Only grants made while I is waiting count toward
                        // starvation; the counter saturates rather than wraps.
                        if (!bus.i_req) begin
                            r_streak <= 3'd0;
                        end else if (r_streak != c_STREAK_SAT) begin
                            r_streak <= r_streak + 3'd1;
                        end
                    end else if (w_grant_i) begin
                        r_state  <= ST_RESP_I;
                        r_err    <= w_i_oor;
                        r_d_read <= 1'b0;
                        r_streak <= 3'd0;
                    end
                end
                ST_RESP_I,
                ST_RESP_D: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
